// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter granting the shared data RAM to one DLX core at a time.
// The winner's request is latched in IDLE and a one-cycle ack carries the read data back.
//
// state | meaning
// IDLE  | no access in flight, arbitrate among pending requests
// ISSUE | strobe mem_en for the latched access (one cycle)
// WAIT  | count memory latency, capture mem_rdata on the last cycle for loads
// DONE  | pulse ack to the winner, advance round-robin pointer
module shared_mem_arbiter #(
   parameter int NUM_CPU = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CPU-1:0]        req,
   input  logic [NUM_CPU-1:0]        we,
   input  logic [NUM_CPU*ADDR_W-1:0] addr,
   input  logic [NUM_CPU*DATA_W-1:0] wdata,
   output logic [NUM_CPU-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_CPU-1:0]        grant,
   output logic                      busy,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CPU - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic                we_l_q, we_l_d;
   logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
   logic [DATA_W-1:0]   wdata_l_q, wdata_l_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_CPU-1:0]  grant_q, grant_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;

   function automatic logic [NUM_CPU-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_CPU-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CPU; k++) begin
         if (IDX_W'(k) == idx) v[k] = 1'b1;
      end
      return v;
   endfunction

   // Search starts one past the previous winner so every core is reached
   // within NUM_CPU arbitrations.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 1; i <= NUM_CPU; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_CPU) cand = cand - NUM_CPU;
         cand_idx = IDX_W'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      we_l_d    = we_l_q;
      addr_l_d  = addr_l_q;
      wdata_l_d = wdata_l_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               win_d     = pick_idx;
               we_l_d    = we[pick_idx];
               addr_l_d  = addr[pick_idx*ADDR_W +: ADDR_W];
               wdata_l_d = wdata[pick_idx*DATA_W +: DATA_W];
               grant_d   = onehot(pick_idx);
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_END) begin
               if (!we_l_q) rdata_d = mem_rdata;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            last_d  = win_q;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         last_q    <= LAST_RST;
         win_q     <= '0;
         we_l_q    <= 1'b0;
         addr_l_q  <= '0;
         wdata_l_q <= '0;
         cnt_q     <= '0;
         grant_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         win_q     <= win_d;
         we_l_q    <= we_l_d;
         addr_l_q  <= addr_l_d;
         wdata_l_q <= wdata_l_d;
         cnt_q     <= cnt_d;
         grant_q   <= grant_d;
         rdata_q   <= rdata_d;
      end
   end

   // Memory port follows the latched request so requester changes after IDLE are ignored.
   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = (state_q == S_ISSUE) && we_l_q;
   assign mem_addr  = addr_l_q;
   assign mem_wdata = wdata_l_q;
   assign ack       = (state_q == S_DONE) ? onehot(win_q) : '0;
   assign grant     = grant_q;
   assign busy      = (state_q != S_IDLE);
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: two cores, MEM_LAT=2, small RAM model.
module tb_shared_mem_arbiter;

   localparam int NUM_CPU = 2;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int MEM_LAT = 2;

   logic                      clock;
   logic                      reset;
   logic [NUM_CPU-1:0]        req;
   logic [NUM_CPU-1:0]        we;
   logic [NUM_CPU*ADDR_W-1:0] addr;
   logic [NUM_CPU*DATA_W-1:0] wdata;
   logic [NUM_CPU-1:0]        ack;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_CPU-1:0]        grant;
   logic                      busy;
   logic                      mem_en;
   logic                      mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;

   logic [DATA_W-1:0] mem [256];

   int tests;
   int fails;

   shared_mem_arbiter #(
      .NUM_CPU(NUM_CPU), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant(grant), .busy(busy), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model: address held stable through WAIT, so a combinational read is valid
   // by the capture cycle.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[8'h10] <= 16'hBEEF;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"},    32'(ack),       32'h0);
      chk({tag, "_grant"},  32'(grant),     32'h0);
      chk({tag, "_busy"},   32'(busy),      32'h0);
      chk({tag, "_mem_en"}, 32'(mem_en),    32'h0);
      chk({tag, "_mem_we"}, 32'(mem_we),    32'h0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;

      // reset state
      step(2);
      chk_idle_outputs("rst");
      chk("rst_rdata",    32'(rdata),     32'h0);
      chk("rst_mem_addr", 32'(mem_addr),  32'h0);
      chk("rst_mem_wd",   32'(mem_wdata), 32'h0);
      reset = 1'b0;
      step(1);

      // core0 load of 0x0010
      req = 2'b01; we = 2'b00;
      addr[0*ADDR_W +: ADDR_W] = 16'h0010;
      step(1);
      chk("ld_mem_en",   32'(mem_en),   32'h1);
      chk("ld_mem_we",   32'(mem_we),   32'h0);
      chk("ld_mem_addr", 32'(mem_addr), 32'h0010);
      chk("ld_grant",    32'(grant),    32'h1);
      chk("ld_busy",     32'(busy),     32'h1);
      chk("ld_ack_i",    32'(ack),      32'h0);
      step(1);
      chk("ld_mem_en_w", 32'(mem_en),   32'h0);
      chk("ld_addr_w",   32'(mem_addr), 32'h0010);
      step(1);
      chk("ld_ack_w2",   32'(ack),      32'h0);
      step(1);
      chk("ld_ack",      32'(ack),      32'h1);
      chk("ld_rdata",    32'(rdata),    32'hBEEF);
      req = 2'b00;
      step(1);
      chk_idle_outputs("ld_end");

      // core1 store 0x1234 to 0x0022, rdata keeps 0xBEEF
      req = 2'b10; we = 2'b10;
      addr[1*ADDR_W +: ADDR_W]  = 16'h0022;
      wdata[1*DATA_W +: DATA_W] = 16'h1234;
      step(1);
      chk("st_mem_en",   32'(mem_en),    32'h1);
      chk("st_mem_we",   32'(mem_we),    32'h1);
      chk("st_mem_wd",   32'(mem_wdata), 32'h1234);
      chk("st_mem_addr", 32'(mem_addr),  32'h0022);
      chk("st_grant",    32'(grant),     32'h2);
      step(3);
      chk("st_ack",      32'(ack),       32'h2);
      chk("st_rdata",    32'(rdata),     32'hBEEF);
      req = 2'b00; we = 2'b00;
      step(1);
      chk_idle_outputs("st_end");
      chk("st_ram",      32'(mem[8'h22]), 32'h1234);

      // both cores requesting continuously: 0,1,0,1
      req = 2'b11; we = 2'b00;
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
         step(3);
         chk("rr_ack",   32'(ack),   (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_rdata", 32'(rdata), (k % 2 == 0) ? 32'hBEEF : 32'h1234);
         step(1);
         chk("rr_ack_off", 32'(ack), 32'h0);
      end

      // core0 holds req across its ack while core1 joins: core1 next, then core0
      req = 2'b01;
      step(1);
      chk("hold_g0", 32'(grant), 32'h1);
      step(3);
      chk("hold_a0", 32'(ack),   32'h1);
      req = 2'b11;
      step(2);
      chk("hold_g1", 32'(grant), 32'h2);
      step(3);
      chk("hold_a1", 32'(ack),   32'h2);
      step(2);
      chk("hold_g0b", 32'(grant), 32'h1);
      req = 2'b00;
      step(3);
      chk("hold_a0b", 32'(ack),  32'h1);
      step(1);

      // async reset during WAIT
      req = 2'b10;
      step(2);
      chk("rw_busy_pre", 32'(busy), 32'h1);
      reset = 1'b1;
      #1;
      chk_idle_outputs("rw");
      chk("rw_rdata",    32'(rdata),    32'h0);
      chk("rw_mem_addr", 32'(mem_addr), 32'h0);
      @(negedge clock);
      reset = 1'b0;
      req = 2'b11;
      addr[1*ADDR_W +: ADDR_W] = 16'h0022;
      step(1);
      chk("rw_first", 32'(grant), 32'h1);

      // core0 moves its address after mem_en: latched address must hold
      req = 2'b01;
      addr[0*ADDR_W +: ADDR_W] = 16'h0055;
      step(1);
      chk("mv_addr_w1", 32'(mem_addr), 32'h0010);
      step(1);
      chk("mv_addr_w2", 32'(mem_addr), 32'h0010);
      step(1);
      chk("mv_ack",     32'(ack),      32'h1);
      chk("mv_addr_d",  32'(mem_addr), 32'h0010);
      chk("mv_rdata",   32'(rdata),    32'hBEEF);
      req = 2'b00;
      step(1);
      chk_idle_outputs("mv_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish by 100000");
      $fatal(1, "timeout");
   end

endmodule
